// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO owner and sequencer for the multi-cycle multiply/divide unit.
// Optional macro MULDIV_FAST_ZERO_EN: one-cycle latency for zero-operand mult / divide-by-zero.
module muldiv_hilo_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_req,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        req_drop
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE_LOAD  = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state_q;
    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   pend_hi_q, pend_lo_q;
    logic          req_drop_q;

    logic [31:0]   pend_hi_d, pend_lo_d;
    logic [CW-1:0] cnt_load_d;
    logic          drop_d;

    logic [63:0]   prod_s, prod_u;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic          is_mul, is_signed, rt_zero;

    assign start    = md_req & ~md_op[2] & ~busy_q;
    assign busy     = busy_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign req_drop = req_drop_q;

    assign is_mul    = ~md_op[1];
    assign is_signed = ~md_op[0];
    assign rt_zero   = (rt_val == 32'd0);
    assign drop_d    = md_req & (busy_q | (md_op[2] & md_op[1]));

    always_comb begin
        prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    end

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        a_mag = rs_val[31] ? (32'd0 - rs_val) : rs_val;
        b_mag = rt_val[31] ? (32'd0 - rt_val) : rt_val;
        q_mag = 32'd0;
        r_mag = 32'd0;
        q_u   = 32'd0;
        r_u   = 32'd0;
        if (!rt_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            q_u   = rs_val / rt_val;
            r_u   = rs_val % rt_val;
        end
        q_s = (rs_val[31] ^ rt_val[31]) ? (32'd0 - q_mag) : q_mag;
        r_s = rs_val[31] ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        pend_hi_d  = hi_q;
        pend_lo_d  = lo_q;
        cnt_load_d = DIV_LOAD;
        if (is_mul) begin
            cnt_load_d = MULT_LOAD;
            pend_hi_d  = is_signed ? prod_s[63:32] : prod_u[63:32];
            pend_lo_d  = is_signed ? prod_s[31:0]  : prod_u[31:0];
        end else if (!rt_zero) begin
            pend_hi_d = is_signed ? r_s : r_u;
            pend_lo_d = is_signed ? q_s : q_u;
        end
`ifdef MULDIV_FAST_ZERO_EN
        if ((is_mul && (rt_zero || rs_val == 32'd0)) || (!is_mul && rt_zero))
            cnt_load_d = ONE_LOAD;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pend_hi_q  <= 32'd0;
            pend_lo_q  <= 32'd0;
            req_drop_q <= 1'b0;
        end else begin
            req_drop_q <= drop_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pend_hi_q <= pend_hi_d;
                        pend_lo_q <= pend_lo_d;
                        cnt_q     <= cnt_load_d;
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                    end else if (md_req && md_op == OP_MTHI) begin
                        hi_q <= rs_val;
                    end else if (md_req && md_op == OP_MTLO) begin
                        lo_q <= rs_val;
                    end
                end
                S_RUN: begin
                    if (cnt_q == ONE_LOAD) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - ONE_LOAD;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, OP_MULT, OP_MULTU, OP_DIV};

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: default instance plus a MULT_CYCLES=1 instance.
module tb_muldiv_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        md_req = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
    logic        start, busy, req_drop;
    logic [31:0] hi_out, lo_out;

    logic        b_req = 1'b0;
    logic [2:0]  b_op = 3'd0;
    logic [31:0] b_rs = 32'd0, b_rt = 32'd0;
    logic        b_start, b_busy, b_drop;
    logic [31:0] b_hi, b_lo;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MULDIV_FAST_ZERO_EN
    localparam int DIV0_CYC = 1;
`else
    localparam int DIV0_CYC = 10;
`endif

    always #5 clk = ~clk;

    muldiv_hilo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .md_req(md_req), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .start(start), .busy(busy),
        .hi_out(hi_out), .lo_out(lo_out), .req_drop(req_drop)
    );

    muldiv_hilo_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .md_req(b_req), .md_op(b_op),
        .rs_val(b_rs), .rt_val(b_rt), .start(b_start), .busy(b_busy),
        .hi_out(b_hi), .lo_out(b_lo), .req_drop(b_drop)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div, count busy cycles, confirm HI/LO hold old values until commit.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        md_req = 1'b1; md_op = op; rs_val = a; rt_val = b;
        #1;
        check({tag, " start"}, start, 1);
        tick();
        md_req = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            if (hi_out !== old_hi || lo_out !== old_lo) begin
                check({tag, " hold_hi"}, hi_out, old_hi);
                check({tag, " hold_lo"}, lo_out, old_lo);
            end
            n++;
            tick();
        end
        check({tag, " busy_cycles"}, n, exp_cyc);
        check({tag, " hi"}, hi_out, exp_hi);
        check({tag, " lo"}, lo_out, exp_lo);
    endtask

    initial begin
        #1;
        check("reset busy", busy, 0);
        check("reset hi", hi_out, 0);
        check("reset lo", lo_out, 0);
        check("reset drop", req_drop, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-RUN discards the divide
        md_req = 1'b1; md_op = 3'd4; rs_val = 32'h55;
        #1; check("mthi start", start, 0);
        tick(); md_req = 1'b0;
        check("mthi hi", hi_out, 32'h55);
        md_req = 1'b1; md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        tick(); md_req = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("rst mid busy", busy, 0);
        check("rst mid hi", hi_out, 0);
        check("rst mid lo", lo_out, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("post rst hi", hi_out, 0);
        check("post rst lo", lo_out, 0);

        run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFE);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'h1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'd3, 32'd7, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);
        run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd1, 32'd3, 32'd0, 32'h8000_0000);

        // Divide by zero leaves preloaded HI/LO
        md_req = 1'b1; md_op = 3'd4; rs_val = 32'h11;
        tick();
        md_op = 3'd5; rs_val = 32'h22;
        tick(); md_req = 1'b0;
        run_op("div0", 3'd2, 32'd5, 32'd0, DIV0_CYC, 32'h11, 32'h22, 32'h11, 32'h22);

        md_req = 1'b1; md_op = 3'd5; rs_val = 32'hABCD;
        #1; check("mtlo start", start, 0);
        tick(); md_req = 1'b0;
        check("mtlo lo", lo_out, 32'hABCD);
        check("mtlo busy", busy, 0);

        // mthi while busy is dropped
        md_req = 1'b1; md_op = 3'd0; rs_val = 32'd3; rt_val = 32'd5;
        tick(); md_req = 1'b0;
        tick(); tick();
        md_req = 1'b1; md_op = 3'd4; rs_val = 32'h1234;
        #1; check("busy mthi start", start, 0);
        tick(); md_req = 1'b0;
        check("busy mthi drop", req_drop, 1);
        check("busy mthi hi", hi_out, 32'h11);
        tick();
        check("drop clears", req_drop, 0);
        check("still busy t5", busy, 1);
        tick();
        check("hazard busy done", busy, 0);
        check("hazard hi", hi_out, 32'd0);
        check("hazard lo", lo_out, 32'd15);

        // Request in tN is dropped; tN+1 is legal
        md_req = 1'b1; md_op = 3'd0; rs_val = 32'd2; rt_val = 32'd2;
        tick(); md_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("tN busy", busy, 1);
        md_req = 1'b1; md_op = 3'd5; rs_val = 32'h99;
        tick(); md_req = 1'b0;
        check("tN drop", req_drop, 1);
        check("tN lo commit", lo_out, 32'd4);
        md_req = 1'b1; md_op = 3'd5; rs_val = 32'h77;
        tick(); md_req = 1'b0;
        check("tN+1 mtlo", lo_out, 32'h77);
        check("tN+1 no drop", req_drop, 0);

        md_req = 1'b1; md_op = 3'd6; rs_val = 32'hDEAD;
        #1; check("rsvd start", start, 0);
        tick(); md_req = 1'b0;
        check("rsvd drop", req_drop, 1);
        check("rsvd busy", busy, 0);
        check("rsvd hi", hi_out, 32'd0);
        check("rsvd lo", lo_out, 32'h77);

        // MULT_CYCLES=1 instance
        b_req = 1'b1; b_op = 3'd0; b_rs = 32'd3; b_rt = 32'd4;
        #1; check("m1 start", b_start, 1);
        tick(); b_req = 1'b0;
        check("m1 busy t1", b_busy, 1);
        check("m1 lo t1", b_lo, 32'd0);
        tick();
        check("m1 busy t2", b_busy, 0);
        check("m1 lo t2", b_lo, 32'd12);
        b_req = 1'b1; b_rs = 32'd5; b_rt = 32'd6;
        #1; check("m1 reissue start", b_start, 1);
        tick(); b_req = 1'b0;
        tick();
        check("m1 second lo", b_lo, 32'd30);
        check("m1 no drop", b_drop, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
- Sequences the multi-cycle multiply/divide unit and owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage.
- Generates the `start`/`busy` pair that the stall logic uses to freeze mfhi/mflo/mult/div/mthi/mtlo in D.
- Holds results until commit and exposes HI/LO to the E-stage mfhi/mflo path.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu; legal range >= 1.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range >= 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- md_req  in  1  E-stage instruction is an HI/LO-class op; already qualified (not a bubble)
- md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved
- rs_val  in  32  forwarded RS operand in E
- rt_val  in  32  forwarded RT operand in E
- start  out  1  combinational; high in the cycle a mult/div is accepted
- busy  out  1  registered; high while an operation is in flight
- hi_out  out  32  current HI register
- lo_out  out  32  current LO register
- req_drop  out  1  registered one-cycle pulse when a request was ignored

Behaviour:

Reset
- rst_n low, asynchronous: busy=0, HI=0, LO=0, counter=0, pending results=0, req_drop=0.
- An in-flight operation is discarded with no HI/LO commit.

States
- IDLE (busy=0) and RUN (busy=1). The counter width is sized to cover max(MULT_CYCLES, DIV_CYCLES).

Issue
- start = md_req & (md_op<=3) & ~busy.
- On the start edge:
  - compute the full result into pending_hi/pending_lo;
  - counter <= MULT_CYCLES or DIV_CYCLES;
  - enter RUN.

Arithmetic
- mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
- multu: unsigned 32x32 -> 64; HI=[63:32], LO=[31:0].
- div/divu: LO=quotient, HI=remainder.
  - Signed results truncate toward zero; remainder takes the sign of the dividend.
  - Divisor 0: pending = current HI/LO, so the operation completes with HI/LO unchanged.
  - Signed 0x80000000 / -1: LO=0x80000000, HI=0.

Timing
- Issue cycle t0; busy=1 for cycles t1..tN, N = latency parameter.
- The counter decrements each RUN cycle.
- At the edge ending tN (counter==1): HI/LO <= pending, busy <= 0.
- An mfhi stalled in D enters E at tN+1 and reads the committed value.

mthi/mtlo
- When md_req & md_op==4/5 & ~busy: HI (or LO) <= rs_val at the next edge.
- No busy, no start.

Requests while busy
- Any md_req while busy is ignored: no state change, req_drop pulses next cycle.
- Stall control guarantees this never occurs; it indicates a hazard bug.

Reserved codes
- md_op 6/7 with md_req is ignored and pulses req_drop.

Simultaneity
- Commit edge and new request in tN: busy is still 1 in tN, so the request is dropped.
- Legal issue is tN+1 or later.

Outputs
- hi_out/lo_out are direct register outputs. Reads never see pending values.

Optional Feature:
- Macro: MULDIV_FAST_ZERO_EN.
- Defined: the counter loads 1 instead of the parameter when
  - mult/multu has rs_val==0 or rt_val==0, or
  - div/divu has rt_val==0.
  busy is then high for exactly one cycle (t1) and the commit happens at the end of t1.
- Undefined: latency is always the full parameter value, independent of operands.

Test Plan:
1. Reset mid-RUN: issue div, assert rst_n low at t3 -> busy=0 immediately, HI=LO=0; a later mfhi reads 0.
2. mult rs=0xFFFFFFFF, rt=2 -> start=1 in t0, busy in t1..t5, HI=0xFFFFFFFF, LO=0xFFFFFFFE visible at t6; HI/LO unchanged through t5. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
3. div rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu rs=7, rt=2 -> LO=3, HI=1.
4. Divide by zero: HI=0x11, LO=0x22 preloaded via mthi/mtlo; div rs=5, rt=0 -> busy 10 cycles (1 with MULDIV_FAST_ZERO_EN); HI/LO still 0x11/0x22.
5. Back-to-back and hazards:
   - mtlo rs=0xABCD while idle -> LO=0xABCD next cycle, busy stays 0, start stays 0.
   - mult in t0 then mthi at t3 -> mthi ignored, req_drop=1 at t4, HI later equals the mult result.
6. Boundary: MULT_CYCLES=1 build; mult 3*4 -> busy only in t1, LO=12 at t2. A mult issued at t2 is accepted (start=1).
